// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Load-use hazard detector and branch/jump flush controller sitting between
//   the control unit and the IF/ID and ID/EX pipeline registers. A small FSM
//   with a down-counter stretches a stall over LOAD_LAT cycles and a flush over
//   FLUSH_CYCLES cycles. All outputs are Mealy, so the first stall/flush cycle
//   happens in the same cycle the condition is seen.
//
//   Optional build macro: HAZARD_STATS_EN adds saturating 16-bit stall/flush
//   event counters.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   pc_src       in   taken branch resolved in EX
//   jmp          in   jump decoded
//   mem_rd       in   EX instruction is a load
//   rg1, rg2     in   ID source registers
//   use_rg2      in   ID instruction actually reads rg2
//   rg_dst_nxt   in   destination register of the EX instruction
//   ext_stall    in   memory-wait freeze request
//   zero_cntrl   out  zero the ID/EX control bits (bubble)
//   pc_write     out  PC write enable
//   ir_write     out  IF/ID write enable
//   flush        out  flush IF/ID
//   busy         out  FSM not in IDLE
//   stall_count  out  (HAZARD_STATS_EN) cycles with zero_cntrl=1
//   flush_count  out  (HAZARD_STATS_EN) cycles with flush=1
module hazard_ctrl_unit #(
  parameter int REG_W        = 5,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_src,
  input  logic             jmp,
  input  logic             mem_rd,
  input  logic [REG_W-1:0] rg1,
  input  logic [REG_W-1:0] rg2,
  input  logic             use_rg2,
  input  logic [REG_W-1:0] rg_dst_nxt,
  input  logic             ext_stall,
  output logic             zero_cntrl,
  output logic             pc_write,
  output logic             ir_write,
  output logic             flush,
`ifdef HAZARD_STATS_EN
  output logic [15:0]      stall_count,
  output logic [15:0]      flush_count,
`endif
  output logic             busy
);

  localparam int MAX_CYC = (LOAD_LAT > FLUSH_CYCLES) ? LOAD_LAT : FLUSH_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic haz;
  logic redirect;

  // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign haz = mem_rd && (rg_dst_nxt != '0) &&
               ((rg_dst_nxt == rg1) || (use_rg2 && (rg_dst_nxt == rg2)));
  assign redirect = pc_src | jmp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    zero_cntrl = 1'b0;
    flush      = 1'b0;
    pc_write   = 1'b1;
    ir_write   = 1'b1;
    busy       = (state_reg != ST_IDLE);

    if (!rst) begin
      // Outputs held at their idle values for the whole reset window.
      busy = 1'b0;
    end else if (ext_stall) begin
      // Freeze: nothing advances and no bubble/flush is issued this cycle.
      pc_write = 1'b0;
      ir_write = 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (redirect) begin
            flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_next = ST_FLUSH;
              cnt_next   = FLUSH_LOAD;
            end
          end else if (haz) begin
            zero_cntrl = 1'b1;
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            if (LOAD_LAT > 1) begin
              state_next = ST_STALL;
              cnt_next   = STALL_LOAD;
            end
          end
        end

        ST_STALL: begin
          if (redirect) begin
            // Redirect squashes the stalled instruction; start the flush instead.
            flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_next = ST_FLUSH;
              cnt_next   = FLUSH_LOAD;
            end else begin
              state_next = ST_IDLE;
              cnt_next   = '0;
            end
          end else begin
            zero_cntrl = 1'b1;
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            if (cnt_reg == CNT_ONE) begin
              state_next = ST_IDLE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg - CNT_ONE;
            end
          end
        end

        ST_FLUSH: begin
          flush = 1'b1;
          if (redirect) begin
            if (FLUSH_CYCLES > 1) begin
              cnt_next = FLUSH_LOAD;
            end else begin
              state_next = ST_IDLE;
              cnt_next   = '0;
            end
          end else if (cnt_reg == CNT_ONE) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - CNT_ONE;
          end
        end

        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  // zero_cntrl and flush are already forced low while ext_stall is set,
  // so the explicit ext_stall term only documents the hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (!ext_stall) begin
      if (zero_cntrl && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
      if (flush && (flush_count != 16'hFFFF))      flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit. Three instances share the stimulus:
//   u[0]: LOAD_LAT=1, FLUSH_CYCLES=1   u[1]: LOAD_LAT=3, FLUSH_CYCLES=1
//   u[2]: LOAD_LAT=3, FLUSH_CYCLES=2
// Each scenario starts with a reset and checks only the instance it targets.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       pc_src, jmp, mem_rd, use_rg2, ext_stall;
  logic [4:0] rg1, rg2, rg_dst_nxt;

  logic zc [3];
  logic pw [3];
  logic iw [3];
  logic fl [3];
  logic bz [3];
`ifdef HAZARD_STATS_EN
  logic [15:0] sc [3];
  logic [15:0] fc [3];
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(1), .FLUSH_CYCLES(1)) u0 (
    .clk(clk), .rst(rst), .pc_src(pc_src), .jmp(jmp), .mem_rd(mem_rd),
    .rg1(rg1), .rg2(rg2), .use_rg2(use_rg2), .rg_dst_nxt(rg_dst_nxt),
    .ext_stall(ext_stall), .zero_cntrl(zc[0]), .pc_write(pw[0]),
    .ir_write(iw[0]), .flush(fl[0]),
`ifdef HAZARD_STATS_EN
    .stall_count(sc[0]), .flush_count(fc[0]),
`endif
    .busy(bz[0]));

  hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(3), .FLUSH_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .pc_src(pc_src), .jmp(jmp), .mem_rd(mem_rd),
    .rg1(rg1), .rg2(rg2), .use_rg2(use_rg2), .rg_dst_nxt(rg_dst_nxt),
    .ext_stall(ext_stall), .zero_cntrl(zc[1]), .pc_write(pw[1]),
    .ir_write(iw[1]), .flush(fl[1]),
`ifdef HAZARD_STATS_EN
    .stall_count(sc[1]), .flush_count(fc[1]),
`endif
    .busy(bz[1]));

  hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(3), .FLUSH_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .pc_src(pc_src), .jmp(jmp), .mem_rd(mem_rd),
    .rg1(rg1), .rg2(rg2), .use_rg2(use_rg2), .rg_dst_nxt(rg_dst_nxt),
    .ext_stall(ext_stall), .zero_cntrl(zc[2]), .pc_write(pw[2]),
    .ir_write(iw[2]), .flush(fl[2]),
`ifdef HAZARD_STATS_EN
    .stall_count(sc[2]), .flush_count(fc[2]),
`endif
    .busy(bz[2]));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks all five control outputs of instance i in one call.
  task automatic chk_out(input string tag, input int i, input logic e_zc,
                         input logic e_pw, input logic e_iw, input logic e_fl,
                         input logic e_bz);
    chk({tag, ".zero_cntrl"}, {15'd0, zc[i]}, {15'd0, e_zc});
    chk({tag, ".pc_write"},   {15'd0, pw[i]}, {15'd0, e_pw});
    chk({tag, ".ir_write"},   {15'd0, iw[i]}, {15'd0, e_iw});
    chk({tag, ".flush"},      {15'd0, fl[i]}, {15'd0, e_fl});
    chk({tag, ".busy"},       {15'd0, bz[i]}, {15'd0, e_bz});
  endtask

  // Drive one cycle's inputs 1 time unit after the rising edge, then let
  // the combinational outputs settle before any check.
  task automatic apply(input logic a_pc, input logic a_jmp, input logic a_mr,
                       input logic [4:0] a_r1, input logic [4:0] a_r2,
                       input logic a_use, input logic [4:0] a_dst,
                       input logic a_ext);
    @(posedge clk);
    #1;
    pc_src = a_pc; jmp = a_jmp; mem_rd = a_mr; rg1 = a_r1; rg2 = a_r2;
    use_rg2 = a_use; rg_dst_nxt = a_dst; ext_stall = a_ext;
    #2;
  endtask

  task automatic idle();
    apply(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    pc_src = 0; jmp = 0; mem_rd = 0; rg1 = 0; rg2 = 0; use_rg2 = 0;
    rg_dst_nxt = 0; ext_stall = 0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    // Reset active with a hazard and a jump present: outputs must be defaults.
    rst = 1'b0;
    pc_src = 0; jmp = 1; mem_rd = 1; rg1 = 5'd5; rg2 = 0; use_rg2 = 0;
    rg_dst_nxt = 5'd5; ext_stall = 0;
    #2;
    for (int i = 0; i < 3; i++) chk_out($sformatf("reset.u%0d", i), i, 0, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single-cycle hazard on the combinational-equivalent build.
    pulse_reset();
    apply(0, 0, 1, 5'd5, 5'd0, 0, 5'd5, 0);
    chk_out("lat1.haz", 0, 1, 0, 0, 0, 0);
    idle();
    chk_out("lat1.after", 0, 0, 1, 1, 0, 0);
    apply(0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    chk_out("lat1.jmp", 0, 0, 1, 1, 1, 0);
    idle();
    chk_out("lat1.jmp_after", 0, 0, 1, 1, 0, 0);

    // LOAD_LAT=3, hazard through rg2.
    pulse_reset();
    apply(0, 0, 1, 5'd3, 5'd7, 1, 5'd7, 0);
    chk_out("lat3.c1", 1, 1, 0, 0, 0, 0);
    idle();
    chk_out("lat3.c2", 1, 1, 0, 0, 0, 1);
    idle();
    chk_out("lat3.c3", 1, 1, 0, 0, 0, 1);
    idle();
    chk_out("lat3.c4", 1, 0, 1, 1, 0, 0);
    apply(0, 0, 1, 5'd3, 5'd7, 0, 5'd7, 0);
    chk_out("lat3.no_use_rg2", 1, 0, 1, 1, 0, 0);
    apply(0, 0, 1, 5'd0, 5'd0, 0, 5'd0, 0);
    chk_out("lat3.r0", 1, 0, 1, 1, 0, 0);
    apply(0, 1, 1, 5'd5, 5'd0, 0, 5'd5, 0);
    chk_out("lat3.jmp_haz", 1, 0, 1, 1, 1, 0);
    idle();
    chk_out("lat3.jmp_after", 1, 0, 1, 1, 0, 0);

    // FLUSH_CYCLES=2: branch aborts a stall on its 2nd cycle.
    pulse_reset();
    apply(0, 0, 1, 5'd9, 5'd0, 0, 5'd9, 0);
    chk_out("abort.c1", 2, 1, 0, 0, 0, 0);
    apply(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    chk_out("abort.c2", 2, 0, 1, 1, 1, 1);
    idle();
    chk_out("abort.c3", 2, 0, 1, 1, 1, 1);
    idle();
    chk_out("abort.c4", 2, 0, 1, 1, 0, 0);

    // ext_stall freeze in the middle of a 3-cycle stall (jmp ignored while frozen).
    pulse_reset();
    apply(0, 0, 1, 5'd4, 5'd0, 0, 5'd4, 0);
    chk_out("frz.c1", 1, 1, 0, 0, 0, 0);
    idle();
    chk_out("frz.c2", 1, 1, 0, 0, 0, 1);
    apply(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 1);
    chk_out("frz.hold1", 1, 0, 0, 0, 0, 1);
    apply(0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 1);
    chk_out("frz.hold2", 1, 0, 0, 0, 0, 1);
    idle();
    chk_out("frz.resume", 1, 1, 0, 0, 0, 1);
    idle();
    chk_out("frz.done", 1, 0, 1, 1, 0, 0);

    // Asynchronous reset in the middle of a stall.
    apply(0, 0, 1, 5'd4, 5'd0, 0, 5'd4, 0);
    chk_out("rstmid.c1", 1, 1, 0, 0, 0, 0);
    idle();
    chk_out("rstmid.c2", 1, 1, 0, 0, 0, 1);
    rst = 1'b0;
    #1;
    chk_out("rstmid.in_reset", 1, 0, 1, 1, 0, 0);
    rst = 1'b1;
    idle();
    chk_out("rstmid.after", 1, 0, 1, 1, 0, 0);

`ifdef HAZARD_STATS_EN
    // Event counters: 4 single-cycle hazards and 3 jumps on the LOAD_LAT=1 build.
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      apply(0, 0, 1, 5'd6, 5'd0, 0, 5'd6, 0);
      idle();
    end
    for (int k = 0; k < 3; k++) begin
      apply(0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
      idle();
    end
    chk("stats.stall_count", sc[0], 16'd4);
    chk("stats.flush_count", fc[0], 16'd3);
    rst = 1'b0;
    #1;
    chk("stats.stall_cleared", sc[0], 16'd0);
    chk("stats.flush_cleared", fc[0], 16'd0);
    rst = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
